// File: rtl/accel_pkg.sv
// accel_pkg: shared channel ids, default widths, request layout and err bit positions for accel_dispatch
package accel_pkg;
  localparam int ACC_H = 0;
  localparam int ACC_E = 1;
  localparam int ACC_D = 2;
  localparam int NUM_CH_DEF = 3;
  localparam int CH_W_DEF = 2;
  localparam int IDX_W_DEF = 11;
  localparam int ERR_SPURIOUS = 0;
  localparam int ERR_BADCH = 1;
  typedef struct packed {
    logic [CH_W_DEF-1:0]  ch;
    logic [IDX_W_DEF-1:0] index;
  } acc_req_t;
endpackage

// File: rtl/accel_dispatch_fifo.sv
// dispatch_fifo: synchronous FIFO of DEPTH x WIDTH with push/pop/full/empty/count, async active-low reset
//   push/wdata: enqueue when not full; pop: dequeue when not empty; rdata: current head (combinational from storage)
module dispatch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0] count_q, count_d;
  logic push_en, pop_en;
  assign full = count_q == (AW+1)'(DEPTH);
  assign empty = count_q == '0;
  assign count = count_q;
  assign rdata = mem_q[rd_ptr_q];
  always_comb begin
    push_en = push & ~full;
    pop_en = pop & ~empty;
    wr_ptr_d = wr_ptr_q + AW'(push_en);
    rd_ptr_d = rd_ptr_q + AW'(pop_en);
    count_d = count_q + (AW+1)'(push_en) - (AW+1)'(pop_en);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
    end
  end
  always_ff @(posedge clk)
    if (push_en) mem_q[wr_ptr_q] <= wdata;
endmodule

// File: rtl/accel_dispatch.sv
// accel_dispatch: queues CPU accelerator commands in order and launches each when its channel is free
//   issue_*: command from decode; issue_ready/stall: backpressure; acc_int/acc_index: launch pulse and index;
//   acc_done: per-channel completion; busy/all_idle: status; err: sticky [0] spurious done, [1] bad channel
module accel_dispatch
  import accel_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int CH_W = CH_W_DEF,
  parameter int IDX_W = IDX_W_DEF,
  parameter int QDEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              issue_valid,
  input  logic [CH_W-1:0]   issue_ch,
  input  logic [IDX_W-1:0]  issue_index,
  output logic              issue_ready,
  output logic              stall,
  output logic [NUM_CH-1:0] acc_int,
  output logic [IDX_W-1:0]  acc_index,
  input  logic [NUM_CH-1:0] acc_done,
  output logic [NUM_CH-1:0] busy,
  output logic              all_idle,
  output logic [1:0]        err
);
  logic [CH_W+IDX_W-1:0] head;
  logic full, empty, accept, bad_ch, push, pop;
  logic [$clog2(QDEPTH):0] count;
  logic [CH_W-1:0] head_ch;
  logic [IDX_W-1:0] head_idx;
  logic [NUM_CH-1:0] head_oh, acc_int_q, acc_int_d, busy_q, busy_d;
  logic [IDX_W-1:0] acc_index_q, acc_index_d;
  logic [1:0] err_q, err_d;
  assign issue_ready = ~full;
  assign stall = issue_valid & full;
  assign acc_int = acc_int_q;
  assign acc_index = acc_index_q;
  assign busy = busy_q;
  assign err = err_q;
  assign all_idle = (count == '0) & ~|busy_q;
  assign head_ch = head[CH_W+IDX_W-1:IDX_W];
  assign head_idx = head[IDX_W-1:0];
  always_comb begin
    head_oh = '0;
    for (int i = 0; i < NUM_CH; i++) head_oh[i] = head_ch == CH_W'(i);
    accept = issue_valid & ~full;
    bad_ch = {1'b0, issue_ch} >= (CH_W+1)'(NUM_CH);
    push = accept & ~bad_ch;
    // dispatch looks at pre-edge busy, so a done on the head's channel delays launch by one edge
    pop = ~empty & ~|(head_oh & busy_q);
    acc_int_d = pop ? head_oh : '0;
    acc_index_d = pop ? head_idx : acc_index_q;
    busy_d = (busy_q & ~acc_done) | acc_int_d;
    err_d = err_q;
    err_d[ERR_SPURIOUS] = err_q[ERR_SPURIOUS] | |(acc_done & ~busy_q);
    err_d[ERR_BADCH] = err_q[ERR_BADCH] | (accept & bad_ch);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_int_q <= '0;
      acc_index_q <= '0;
      busy_q <= '0;
      err_q <= '0;
    end else begin
      acc_int_q <= acc_int_d;
      acc_index_q <= acc_index_d;
      busy_q <= busy_d;
      err_q <= err_d;
    end
  end
  dispatch_fifo #(.DEPTH(QDEPTH), .WIDTH(CH_W + IDX_W)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .push(push),
    .wdata({issue_ch, issue_index}),
    .pop(pop),
    .rdata(head),
    .full(full),
    .empty(empty),
    .count(count)
  );
endmodule

// File: doc/accel_dispatch.md
# accel_dispatch

Parametrised accelerator dispatch unit for the general-purpose CPU. Generalises the fixed three-line hash/encrypt/decrypt start/done handshake to NUM_CH accelerator channels. CPU start requests are buffered in an in-order queue, each launched when its target channel is free, and per-channel busy state is tracked until that channel's done returns. Sits between the decode stage, which issues accelerator commands, and the accelerator tops; drives the pipeline stall when the queue cannot accept a command.

## Interface
- NUM_CH, 3: number of accelerator channels (0 = H, 1 = E, 2 = D by default).
- CH_W, 2: channel-id width, at least clog2(NUM_CH).
- IDX_W, 11: width of the data index passed to an accelerator.
- QDEPTH, 4: request queue depth, power of two, at least 2.

Ports:
- clk  in  1  system clock; all state on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- issue_valid  in  1  decode presents an accelerator command.
- issue_ch  in  CH_W  target channel.
- issue_index  in  IDX_W  data index for the command.
- issue_ready  out  1  queue can accept a command this cycle.
- stall  out  1  issue_valid & ~issue_ready; freezes IfId/IdEx.
- acc_int  out  NUM_CH  one-cycle start pulse per channel.
- acc_index  out  IDX_W  index of the most recently launched command.
- acc_done  in  NUM_CH  per-channel completion pulse.
- busy  out  NUM_CH  channel launched and not yet done.
- all_idle  out  1  queue empty and no channel busy.
- err  out  2  sticky flags: [0] spurious done, [1] illegal channel id.

## Operation
- Reset values: acc_int=0, acc_index=0, busy=0, err=0, queue empty, issue_ready=1, stall=0, all_idle=1.
- Accept: on a posedge with issue_valid & issue_ready, {issue_ch, issue_index} is pushed. If issue_ch >= NUM_CH, the command is dropped (not pushed) and err[1] is set.
- issue_ready = ~full, taken from the registered count. There is no push-through when full, even if a pop occurs in the same cycle.
- Dispatch: when the queue is non-empty and busy[head.ch]=0, pop the head. On the same edge set acc_int[head.ch]=1, acc_index=head.index, busy[head.ch]=1.
- Strict in-order dispatch: a busy head blocks later entries, even entries for idle channels.
- Completion: acc_done[c] with busy[c]=1 clears busy[c] on that edge. acc_done[c] with busy[c]=0 sets err[0] and leaves busy unchanged.
- Done and dispatch on the same channel in the same cycle: dispatch uses the pre-edge busy value, so the head stalls one more cycle and launches on the next edge.
- Push and pop in the same cycle: allowed when not full; count is unchanged.
- Pointers wrap modulo QDEPTH. The count is clog2(QDEPTH)+1 bits wide.
- Reset mid-operation clears the queue, busy, and pending pulses immediately. Late acc_done pulses after reset set err[0].

## Timing
- Command accepted at edge k: acc_int is high during the cycle after edge k+1, provided the channel is free. Minimum latency is 2 edges.
- acc_int is high for exactly one cycle per launch.
- acc_index holds its value until the next launch on any channel.
- Throughput: one launch per cycle across distinct free channels.
- Back-to-back commands to the same channel: second launch no earlier than one edge after the first channel's done.
- stall is combinational from issue_valid and a registered full flag. There is no other combinational input-to-output path.

## Structure
- Shared package accel_pkg holds: channel constants ACC_H=0, ACC_E=1, ACC_D=2; default IDX_W=11; the request struct {ch, index}; err bit positions ERR_SPURIOUS=0, ERR_BADCH=1.
- Sub-module dispatch_fifo: synchronous FIFO with DEPTH and WIDTH parameters, push/pop/full/empty/count, and asynchronous active-low reset.
- Top level contains dispatch logic, the busy vector, the err flags, and output registers.

## Test plan
- Single command: issue ch=1, index=0x2A5. acc_int=3'b010 for one cycle 2 edges later, acc_index=0x2A5, busy[1]=1. Pulse acc_done[1]: busy=0, all_idle=1.
- Head-of-line blocking: issue ch0 then ch0 then ch2 without any done. Second ch0 and ch2 are not launched. After acc_done[0], the second ch0 launches, then ch2 on the following edge.
- Full queue with QDEPTH=4 and all channels held busy: push 4 commands, issue_ready=0. A fifth issue_valid gives stall=1 and the queue count stays 4 until a pop.
- Same-cycle done and pending head: busy[2]=1, head targets ch2, acc_done[2] pulses. Launch occurs exactly one edge after busy clears, never on the done edge.
- Errors: acc_done[0] while idle sets err=2'b01. Issue ch=3 with NUM_CH=3 sets err[1], no push, no acc_int. Both flags stay set until rst_n=0.
- Reset mid-operation: rst_n low with 3 entries queued and busy=3'b111. All outputs return to reset values asynchronously and nothing launches after release.
